// File: rtl/tdc_pulse_meter.sv
`timescale 1ns/1ps
// tdc_pulse_meter
//   Measures the high time of the asynchronous stop_in pulse in clk cycles and
//   offers one result per pulse on a valid/ready output port.
//   Path: SYNC_STAGES-flop synchroniser -> FILT_LEN-sample level filter -> FSM.
//   Handshake: meas_valid rises with a result and stays high, with meas_data and
//   meas_ovf frozen, until a cycle where meas_valid && meas_ready; the result
//   is consumed on that clock edge and meas_valid drops the cycle after.
//   Optional feature: define TDC_DROP_CNT_EN to add the drop_cnt output, which
//   counts pulses that arrive while a result is still waiting (saturates at 255).
module tdc_pulse_meter #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stop_in,
    input  logic             meas_ready,
    output logic             meas_valid,
    output logic [CNT_W-1:0] meas_data,
    output logic             meas_ovf,
`ifdef TDC_DROP_CNT_EN
    output logic [7:0]       drop_cnt,
`endif
    output logic             busy
);

    localparam int FCNT_W = $clog2(FILT_LEN + 1);
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILT_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_ARM     = 2'd0,
        ST_IDLE    = 2'd1,
        ST_MEASURE = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;
    logic                   filt_q, filt_d;
    logic [FCNT_W-1:0]      fcnt_q, fcnt_d;
    logic                   settle_q;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic [CNT_W-1:0]       data_q, data_d;
    logic                   dovf_q, dovf_d;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Synchroniser shift chain for the asynchronous stop input.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], stop_in};
        end
    end

    // Level filter: the filtered level follows s only after FILT_LEN consecutive
    // differing samples, so both edges get the same delay and widths survive.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (sync_s != filt_q) begin
            if (fcnt_q == FCNT_LAST) begin
                filt_d = sync_s;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    // Filter state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_q <= 1'b0;
            fcnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    // Next-state and datapath logic. ARM only releases once the whole input path
    // is quiet. The first cycle after reset is always spent in ARM (settle_q low)
    // so a pulse already high at reset release reaches the sync chain and keeps
    // ARM waiting until that pulse has completely gone.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        data_d  = data_q;
        dovf_d  = dovf_q;
        case (state_q)
            ST_ARM: begin
                if (settle_q && !filt_q && (fcnt_q == '0) && (sync_q == '0)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                // f is known low on entry, so f high here is its rising edge.
                if (filt_q) begin
                    state_d = ST_MEASURE;
                    cnt_d   = CNT_W'(1);
                    ovf_d   = 1'b0;
                end
            end
            ST_MEASURE: begin
                if (filt_q) begin
                    if (cnt_q == CNT_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    data_d  = cnt_q;
                    dovf_d  = ovf_q;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (meas_ready) begin
                    state_d = ST_ARM;
                end
            end
            default: state_d = ST_ARM;
        endcase
    end

    // FSM, counter and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_ARM;
            settle_q <= 1'b0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            data_q   <= '0;
            dovf_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= 1'b1;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            data_q   <= data_d;
            dovf_q   <= dovf_d;
        end
    end

    assign meas_valid = (state_q == ST_HOLD);
    assign busy       = (state_q == ST_MEASURE) || (state_q == ST_HOLD);
    assign meas_data  = data_q;
    assign meas_ovf   = dovf_q;

`ifdef TDC_DROP_CNT_EN
    logic       filt_prev_q;
    logic [7:0] drop_q;

    // Count rising edges of the filtered level seen while a result is held.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_prev_q <= 1'b0;
            drop_q      <= '0;
        end else begin
            filt_prev_q <= filt_q;
            if ((state_q == ST_HOLD) && filt_q && !filt_prev_q && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_tdc_pulse_meter.sv
`timescale 1ns/1ps
// Bench for tdc_pulse_meter: directed scenarios plus randomized pulse widths
// against a pulse-level reference model (width -> saturated count, overflow flag).
module tb_tdc_pulse_meter;

    localparam int CNT_W       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int FILT_LEN    = 3;
    localparam int CNT_MAX_I   = (1 << CNT_W) - 1;
    localparam int LATENCY     = SYNC_STAGES + FILT_LEN + 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             stop_in = 1'b0;
    logic             meas_ready = 1'b0;
    logic             meas_valid;
    logic [CNT_W-1:0] meas_data;
    logic             meas_ovf;
    logic             busy;
`ifdef TDC_DROP_CNT_EN
    logic [7:0]       drop_cnt;
`endif

    tdc_pulse_meter #(
        .CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stop_in    (stop_in),
        .meas_ready (meas_ready),
        .meas_valid (meas_valid),
        .meas_data  (meas_data),
        .meas_ovf   (meas_ovf),
`ifdef TDC_DROP_CNT_EN
        .drop_cnt   (drop_cnt),
`endif
        .busy       (busy)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;
    int n_xfer = 0;
    int valid_cycles = 0;
    bit busy_seen = 1'b0;
    bit rand_ready = 1'b0;

    // Scoreboard entries: {ovf, data}
    logic [CNT_W:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // A pulse of w cycles is reported iff it survives the filter (w >= FILT_LEN);
    // the count saturates at 2^CNT_W-1 and overflow means w was beyond that.
    task automatic model_pulse(input int w);
        logic [CNT_W:0] item;
        if (w >= FILT_LEN) begin
            item[CNT_W]     = (w > CNT_MAX_I);
            item[CNT_W-1:0] = (w > CNT_MAX_I) ? CNT_W'(CNT_MAX_I) : CNT_W'(w);
            exp_q.push_back(item);
        end
    endtask

    // ---------------- monitor (samples on falling edge) ----------------
    always @(negedge clk) begin
        if (!reset) begin
            if (meas_valid) valid_cycles++;
            if (busy) busy_seen = 1'b1;
            if (meas_valid && meas_ready) begin
                n_xfer++;
                check_eq("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    logic [CNT_W:0] item;
                    item = exp_q.pop_front();
                    check_eq("xfer_data", 32'(meas_data), 32'(item[CNT_W-1:0]));
                    check_eq("xfer_ovf", 32'(meas_ovf), 32'(item[CNT_W]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rand_ready) meas_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic pulse(input int w);
        stop_in = 1'b1;
        tick(w);
        stop_in = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget && (exp_q.size() != 0 || busy); i++) tick(1);
        check_eq(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_valid_count(output int n);
        n = 0;
        while (!meas_valid && n < 50) begin
            tick(1);
            n++;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n0;
        int lat;
        int w;

        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        check_eq("rst_valid", 32'(meas_valid), 32'd0);
        check_eq("rst_data", 32'(meas_data), 32'd0);
        check_eq("rst_ovf", 32'(meas_ovf), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
`ifdef TDC_DROP_CNT_EN
        check_eq("rst_drop", 32'(drop_cnt), 32'd0);
`endif
        tick(5);

        // 1: clean 10-cycle pulse
        meas_ready = 1'b1;
        valid_cycles = 0;
        pulse(10);
        model_pulse(10);
        drain("t1_drain", 200);
        tick(5);
        check_eq("t1_valid_cycles", 32'(valid_cycles), 32'd1);

        // 2: glitch filtered, exact FILT_LEN pulse passes
        busy_seen = 1'b0;
        n0 = n_xfer;
        pulse(2);
        tick(20);
        check_eq("t2_glitch_busy", 32'(busy_seen), 32'd0);
        check_eq("t2_glitch_xfer", 32'(n_xfer), 32'(n0));
        pulse(3);
        model_pulse(3);
        drain("t2_drain", 200);
        tick(5);

        // 3: overflow then normal
        pulse(300);
        model_pulse(300);
        drain("t3_drain_ovf", 200);
        tick(5);
        pulse(4);
        model_pulse(4);
        drain("t3_drain", 200);
        tick(5);

        // 4: held result not overwritten, pulse during HOLD dropped
        meas_ready = 1'b0;
        n0 = n_xfer;
        pulse(20);
        model_pulse(20);
        wait_valid_count(lat);
        check_eq("t4_valid_seen", 32'(meas_valid), 32'd1);
        tick(3);
        pulse(7);
        tick(50);
        check_eq("t4_hold_valid", 32'(meas_valid), 32'd1);
        check_eq("t4_hold_data", 32'(meas_data), 32'd20);
        check_eq("t4_hold_ovf", 32'(meas_ovf), 32'd0);
        check_eq("t4_pending", 32'(exp_q.size()), 32'd1);
`ifdef TDC_DROP_CNT_EN
        check_eq("t4_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
        meas_ready = 1'b1;
        drain("t4_drain", 200);
        tick(30);
        check_eq("t4_one_xfer", 32'(n_xfer), 32'(n0 + 1));

        // 5: reset mid-pulse, pulse still high after release
        n0 = n_xfer;
        stop_in = 1'b1;
        tick(15);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        busy_seen = 1'b0;
        check_eq("t5_rst_valid", 32'(meas_valid), 32'd0);
`ifdef TDC_DROP_CNT_EN
        check_eq("t5_drop_cleared", 32'(drop_cnt), 32'd0);
`endif
        tick(10);
        stop_in = 1'b0;
        tick(30);
        check_eq("t5_no_xfer", 32'(n_xfer), 32'(n0));
        check_eq("t5_no_busy", 32'(busy_seen), 32'd0);
        pulse(5);
        model_pulse(5);
        drain("t5_drain", 200);
        tick(5);

        // 6: two 6-cycle pulses 10 cycles apart, fixed latency
        pulse(6);
        model_pulse(6);
        wait_valid_count(lat);
        check_eq("t6_latency_a", 32'(lat), 32'(LATENCY));
        tick(10 - lat);
        pulse(6);
        model_pulse(6);
        wait_valid_count(lat);
        check_eq("t6_latency_b", 32'(lat), 32'(LATENCY));
        drain("t6_drain", 200);
        tick(5);

        // Randomized widths with random consumer back-pressure
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) w = int'($urandom_range(250, 300));
            else w = int'($urandom_range(1, 30));
            pulse(w);
            model_pulse(w);
            drain("rand_drain", 1000);
            tick(int'($urandom_range(FILT_LEN + 2, 12)));
        end
        rand_ready = 1'b0;
        meas_ready = 1'b1;
        tick(20);
        check_eq("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check_eq("final_valid_low", 32'(meas_valid), 32'd0);
`ifdef TDC_DROP_CNT_EN
        check_eq("final_drop_cnt", 32'(drop_cnt), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
